// File: rtl/ppa_pkg.sv
// Shared types and sizing helpers for the Kogge-Stone prefix adder.
// Prefix nodes carry a (generate, propagate) pair.
package ppa_pkg;

   localparam int KS_DEFAULT_WIDTH = 22;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // ceil(log2(n)); 0 for n <= 1
   function automatic int ks_stages(input int n);
      int s;
      s = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) s = i + 1;
      end
      return s;
   endfunction

endpackage

// File: rtl/ks_black_cell.sv
// Kogge-Stone black cell: merges a high group with the adjacent low group.
// G = Gh | (Ph & Gl), P = Ph & Pl.
module ks_black_cell (
   input  logic gh,
   input  logic ph,
   input  logic gl,
   input  logic pl,
   output logic g,
   output logic p
);

   assign g = gh | (ph & gl);
   assign p = ph & pl;

endmodule

// File: rtl/ppa_kogge_stone_22bit.sv
// Kogge-Stone parallel-prefix adder {cout, S} = A + B + cin.
// Define PPA_KS_OUT_REG_EN to register S/cout (async active-low reset).
module ppa_kogge_stone_22bit
   import ppa_pkg::*;
#(
   parameter int width = KS_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] A,
   input  logic [width-1:0] B,
   input  logic             cin,
   output logic [width-1:0] S,
   output logic             cout
);

   // position 0 holds cin; bit i of the operands sits at position i+1
   localparam int N = width + 1;
   localparam int L = ks_stages(N);

   gp_t              node [L+1][N];
   logic [width-1:0] sum_c;
   logic             cout_c;
   logic [N-1:0]     final_p;
   logic             unused_final_p;

   assign node[0][0] = '{g: cin, p: 1'b0};

   genvar i, j, k;
   generate
      for (i = 0; i < width; i++) begin : g_pre
         assign node[0][i+1] = '{g: A[i] & B[i], p: A[i] ^ B[i]};
      end

      for (k = 1; k <= L; k++) begin : g_stage
         localparam int D = 1 << (k - 1);
         for (j = 0; j < N; j++) begin : g_pos
            if (j >= D) begin : g_cell
               logic cg;
               logic cp;
               ks_black_cell u_cell (
                  .gh (node[k-1][j].g),
                  .ph (node[k-1][j].p),
                  .gl (node[k-1][j-D].g),
                  .pl (node[k-1][j-D].p),
                  .g  (cg),
                  .p  (cp)
               );
               assign node[k][j] = '{g: cg, p: cp};
            end else begin : g_pass
               assign node[k][j] = node[k-1][j];
            end
         end
      end

      for (i = 0; i < width; i++) begin : g_sum
         assign sum_c[i] = node[0][i+1].p ^ node[L][i].g;
      end

      for (j = 0; j < N; j++) begin : g_fp
         assign final_p[j] = node[L][j].p;
      end
   endgenerate

   assign cout_c         = node[L][width].g;
   assign unused_final_p = ^final_p;

`ifdef PPA_KS_OUT_REG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S    <= '0;
         cout <= 1'b0;
      end else begin
         S    <= sum_c;
         cout <= cout_c;
      end
   end
`else
   logic unused_clk_rst;

   assign S              = sum_c;
   assign cout           = cout_c;
   assign unused_clk_rst = clk ^ rst_n;
`endif

endmodule

// File: tb/tb_ppa_kogge_stone_22bit.sv
// Self-checking bench for ppa_kogge_stone_22bit against an arithmetic model.
// Covers both the combinational and PPA_KS_OUT_REG_EN builds.
module tb_ppa_kogge_stone_22bit;

   localparam int W = 22;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [W-1:0] s;
   logic         cout;

   int total;
   int fails;

   ppa_kogge_stone_22bit dut (
      .clk  (clk),
      .rst_n(rst_n),
      .A    (a),
      .B    (b),
      .cin  (cin),
      .S    (s),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W:0] model(input logic [W-1:0] x,
                                        input logic [W-1:0] y,
                                        input logic         c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   task automatic chk_s(input string tag, input logic [W-1:0] exp_s);
      total++;
      assert (s === exp_s)
      else begin
         fails++;
         $error("FAIL %s S: got %h expected %h", tag, s, exp_s);
      end
   endtask

   task automatic chk_c(input string tag, input logic exp_c);
      total++;
      assert (cout === exp_c)
      else begin
         fails++;
         $error("FAIL %s cout: got %b expected %b", tag, cout, exp_c);
      end
   endtask

   // drive away from the rising edge, then sample once the result is due
   task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c);
      @(negedge clk);
      a   = x;
      b   = y;
      cin = c;
`ifdef PPA_KS_OUT_REG_EN
      @(posedge clk);
`endif
      #1;
   endtask

   task automatic run(input string tag, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic c);
      logic [W:0] r;
      r = model(x, y, c);
      apply(x, y, c);
      chk_s(tag, r[W-1:0]);
      chk_c(tag, r[W]);
   endtask

   initial begin
      logic [W:0] r;
      total = 0;
      fails = 0;
      rst_n = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      #1;
      chk_s("reset", '0);
      chk_c("reset", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      run("zero", 22'h000000, 22'h000000, 1'b0);
      chk_s("zero_k", 22'h000000);
      run("max", 22'h3FFFFF, 22'h3FFFFF, 1'b1);
      chk_s("max_k", 22'h3FFFFF);
      chk_c("max_k", 1'b1);
      run("ripple", 22'h3FFFFF, 22'h000000, 1'b1);
      chk_s("ripple_k", 22'h000000);
      chk_c("ripple_k", 1'b1);
      run("alt0", 22'h155555, 22'h2AAAAA, 1'b0);
      chk_s("alt0_k", 22'h3FFFFF);
      chk_c("alt0_k", 1'b0);
      run("alt1", 22'h155555, 22'h2AAAAA, 1'b1);
      chk_s("alt1_k", 22'h000000);
      chk_c("alt1_k", 1'b1);
      run("msb", 22'h200000, 22'h200000, 1'b0);
      run("one", 22'h000000, 22'h000000, 1'b1);

      for (int n = 0; n < 64; n++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         ra = $urandom;
         rb = $urandom;
         run("rand", ra[W-1:0], rb[W-1:0], 1'($urandom_range(1, 0)));
      end

`ifdef PPA_KS_OUT_REG_EN
      run("pre_rst", 22'h123456, 22'h0ABCDE, 1'b1);
      @(negedge clk);
      a     = 22'h2F0F0F;
      b     = 22'h10F0F1;
      cin   = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_s("mid_rst", '0);
      chk_c("mid_rst", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      r = model(22'h2F0F0F, 22'h10F0F1, 1'b0);
      chk_s("post_rst", r[W-1:0]);
      chk_c("post_rst", r[W]);
`else
      r = model(22'h2F0F0F, 22'h10F0F1, 1'b0);
      a     = 22'h2F0F0F;
      b     = 22'h10F0F1;
      cin   = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_s("rst_ignored", r[W-1:0]);
      chk_c("rst_ignored", r[W]);
      rst_n = 1'b1;
`endif

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
